// File: rtl/apb_quad_counter.sv
// apb_quad_counter: multi-channel quadrature encoder counter on an APB slave.
// Each channel synchronises its A/B/Z pins, runs a programmable glitch filter,
// decodes x1/x2/x4 steps into a wrapping counter, captures the count on index
// rising edges and raises a level interrupt from its sticky status flags.
//
// Ports:
//   sys_clock    - sole clock for encoder logic and APB
//   reset        - asynchronous, active-high reset
//   enc_a/b/z    - per-channel encoder phase A, phase B and index (async pins)
//   apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata - APB slave inputs
//   apb_prdata   - registered read data (captured in the setup phase)
//   irq          - per-channel registered level interrupt
//
// Channel n occupies byte offsets n*0x10 + {0x0 CTRL, 0x4 COUNT, 0x8 CAPTURE, 0xC STAT}.
module apb_quad_counter #(
    parameter int CHANNELS  = 2,
    parameter int CNT_BITS  = 32,
    parameter int FILT_BITS = 4,
    parameter int ADDR_BITS = 12
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enc_a,
    input  logic [CHANNELS-1:0]  enc_b,
    input  logic [CHANNELS-1:0]  enc_z,
    input  logic                 apb_psel,
    input  logic                 apb_penable,
    input  logic                 apb_pwrite,
    input  logic [ADDR_BITS-1:0] apb_paddr,
    input  logic [31:0]          apb_pwdata,
    output logic [31:0]          apb_prdata,
    output logic [CHANNELS-1:0]  irq
);

    localparam int CH_W = ADDR_BITS - 4;

    logic [CH_W-1:0]            ch_s;
    logic [3:0]                 off_s;
    logic                       ch_ok_s;
    logic                       wr_s;
    logic                       rd_setup_s;
    logic [CHANNELS-1:0]        hit_s;
    logic [CHANNELS-1:0][31:0]  rd_words_s;
    logic [31:0]                rdata_s;
    logic                       unused_s;

    assign ch_s       = apb_paddr[ADDR_BITS-1:4];
    assign off_s      = apb_paddr[3:0];
    assign ch_ok_s    = (ch_s < CH_W'(CHANNELS));
    assign wr_s       = apb_psel & apb_penable & apb_pwrite;
    assign rd_setup_s = apb_psel & ~apb_penable & ~apb_pwrite;
    // Not every write-data bit reaches a register field.
    assign unused_s   = ^apb_pwdata;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        // Signal bundles are ordered {a, b, z}.
        logic [2:0]           sync1_r;
        logic [2:0]           sync2_r;
        logic [2:0]           filt_out_r;
        logic [FILT_BITS-1:0] filt_cnt_r [3];

        logic                 en_r;
        logic [1:0]           mode_r;
        logic                 dir_inv_r;
        logic                 zclr_r;
        logic                 ie_idx_r;
        logic                 ie_err_r;
        logic [FILT_BITS-1:0] filt_r;

        logic [1:0]           prev_ab_r;
        logic                 prev_z_r;
        logic [CNT_BITS-1:0]  count_r;
        logic [CNT_BITS-1:0]  capture_r;
        logic                 idx_r;
        logic                 err_r;
        logic                 irq_r;

        logic                 sel_s;
        logic                 wr_ctrl_s;
        logic                 wr_count_s;
        logic                 wr_stat_s;
        logic [1:0]           ab_s;
        logic                 z_s;
        logic                 a_chg_s;
        logic                 b_chg_s;
        logic                 fwd_s;
        logic                 step_s;
        logic                 up_s;
        logic                 illegal_s;
        logic                 z_rise_s;
        logic [31:0]          word_s;

        assign sel_s      = ch_ok_s & (ch_s == CH_W'(n));
        assign hit_s[n]   = sel_s;
        assign wr_ctrl_s  = wr_s & sel_s & (off_s == 4'h0);
        assign wr_count_s = wr_s & sel_s & (off_s == 4'h4);
        assign wr_stat_s  = wr_s & sel_s & (off_s == 4'hC);

        assign ab_s      = filt_out_r[2:1];
        assign z_s       = filt_out_r[0];
        assign a_chg_s   = ab_s[1] ^ prev_ab_r[1];
        assign b_chg_s   = ab_s[0] ^ prev_ab_r[0];
        // For a single-phase change, the step is forward exactly when the old A equals the new B.
        assign fwd_s     = ~(prev_ab_r[1] ^ ab_s[0]);
        assign illegal_s = a_chg_s & b_chg_s;
        assign z_rise_s  = z_s & ~prev_z_r;

        // Two-flop synchroniser for the asynchronous encoder pins.
        always_ff @(posedge sys_clock or posedge reset) begin
            if (reset) begin
                sync1_r <= 3'b000;
                sync2_r <= 3'b000;
            end else begin
                sync1_r <= {enc_a[n], enc_b[n], enc_z[n]};
                sync2_r <= sync1_r;
            end
        end

        // Glitch filter: accept a new level after it has differed for filt+1 cycles.
        always_ff @(posedge sys_clock or posedge reset) begin
            if (reset) begin
                filt_out_r <= 3'b000;
                for (int k = 0; k < 3; k++) begin
                    filt_cnt_r[k] <= '0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (sync2_r[k] == filt_out_r[k]) begin
                        filt_cnt_r[k] <= '0;
                    end else if (filt_cnt_r[k] == filt_r) begin
                        filt_out_r[k] <= sync2_r[k];
                        filt_cnt_r[k] <= '0;
                    end else begin
                        filt_cnt_r[k] <= filt_cnt_r[k] + FILT_BITS'(1);
                    end
                end
            end
        end

        // CTRL register.
        always_ff @(posedge sys_clock or posedge reset) begin
            if (reset) begin
                en_r      <= 1'b0;
                mode_r    <= 2'b00;
                dir_inv_r <= 1'b0;
                zclr_r    <= 1'b0;
                ie_idx_r  <= 1'b0;
                ie_err_r  <= 1'b0;
                filt_r    <= '0;
            end else if (wr_ctrl_s) begin
                en_r      <= apb_pwdata[0];
                mode_r    <= apb_pwdata[2:1];
                dir_inv_r <= apb_pwdata[3];
                zclr_r    <= apb_pwdata[4];
                ie_idx_r  <= apb_pwdata[5];
                ie_err_r  <= apb_pwdata[6];
                filt_r    <= apb_pwdata[FILT_BITS+7:8];
            end else begin
                en_r      <= en_r;
                mode_r    <= mode_r;
                dir_inv_r <= dir_inv_r;
                zclr_r    <= zclr_r;
                ie_idx_r  <= ie_idx_r;
                ie_err_r  <= ie_err_r;
                filt_r    <= filt_r;
            end
        end

        // Step qualification by decode mode; up_s already includes direction inversion.
        always_comb begin
            step_s = 1'b0;
            up_s   = 1'b0;
            if (a_chg_s ^ b_chg_s) begin
                case (mode_r)
                    2'b01: begin
                        step_s = a_chg_s;
                        up_s   = fwd_s ^ dir_inv_r;
                    end
                    2'b10: begin
                        step_s = a_chg_s & ab_s[1];
                        up_s   = ~ab_s[0] ^ dir_inv_r;
                    end
                    default: begin
                        step_s = 1'b1;
                        up_s   = fwd_s ^ dir_inv_r;
                    end
                endcase
            end else begin
                step_s = 1'b0;
                up_s   = 1'b0;
            end
        end

        // Count, capture, status flags and interrupt; previous state tracks even when disabled.
        always_ff @(posedge sys_clock or posedge reset) begin
            if (reset) begin
                prev_ab_r <= 2'b00;
                prev_z_r  <= 1'b0;
                count_r   <= '0;
                capture_r <= '0;
                idx_r     <= 1'b0;
                err_r     <= 1'b0;
                irq_r     <= 1'b0;
            end else begin
                prev_ab_r <= ab_s;
                prev_z_r  <= z_s;
                if (wr_count_s) begin
                    count_r <= apb_pwdata[CNT_BITS-1:0];
                end else if (en_r && z_rise_s && zclr_r) begin
                    count_r <= '0;
                end else if (en_r && step_s) begin
                    count_r <= up_s ? count_r + CNT_BITS'(1) : count_r - CNT_BITS'(1);
                end else begin
                    count_r <= count_r;
                end
                if (en_r && z_rise_s) begin
                    capture_r <= count_r;
                end else begin
                    capture_r <= capture_r;
                end
                // Hardware set is ORed in after the W1C so it wins a same-cycle clear.
                idx_r <= (idx_r & ~(wr_stat_s & apb_pwdata[0])) | (en_r & z_rise_s);
                err_r <= (err_r & ~(wr_stat_s & apb_pwdata[1])) | (en_r & illegal_s);
                irq_r <= (idx_r & ie_idx_r) | (err_r & ie_err_r);
            end
        end

        // Per-channel read word, zero-extended.
        always_comb begin
            case (off_s)
                4'h0:    word_s = 32'({filt_r, 1'b0, ie_err_r, ie_idx_r, zclr_r, dir_inv_r, mode_r, en_r});
                4'h4:    word_s = 32'(count_r);
                4'h8:    word_s = 32'(capture_r);
                4'hC:    word_s = {30'd0, err_r, idx_r};
                default: word_s = 32'd0;
            endcase
        end

        assign rd_words_s[n] = word_s;
        assign irq[n]        = irq_r;
    end

    // Read mux across channels; an unselected or out-of-range channel contributes zero.
    always_comb begin
        rdata_s = 32'd0;
        for (int n = 0; n < CHANNELS; n++) begin
            rdata_s = rdata_s | (hit_s[n] ? rd_words_s[n] : 32'd0);
        end
    end

    // Read data captured in the setup phase and held until the next read setup.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            apb_prdata <= 32'd0;
        end else if (rd_setup_s) begin
            apb_prdata <= rdata_s;
        end else begin
            apb_prdata <= apb_prdata;
        end
    end

endmodule

// File: tb/tb_apb_quad_counter.sv
// Scoreboard bench for apb_quad_counter: stimulus tasks push expected values,
// a negedge monitor pops and compares on every APB read access or probe.
module tb_apb_quad_counter;

    logic        sys_clock = 1'b0;
    logic        reset;
    logic [1:0]  enc_a, enc_b, enc_z;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [11:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata, prdata16;
    logic [1:0]  irq;
    logic        irq16;

    always #5 sys_clock = ~sys_clock;

    apb_quad_counter #(.CHANNELS(2), .CNT_BITS(32), .FILT_BITS(4), .ADDR_BITS(12)) dut (
        .sys_clock(sys_clock), .reset(reset),
        .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
        .apb_prdata(apb_prdata), .irq(irq)
    );

    // Narrow-counter instance sharing the bus and channel-0 pins.
    apb_quad_counter #(.CHANNELS(1), .CNT_BITS(16), .FILT_BITS(4), .ADDR_BITS(12)) dut16 (
        .sys_clock(sys_clock), .reset(reset),
        .enc_a(enc_a[0:0]), .enc_b(enc_b[0:0]), .enc_z(enc_z[0:0]),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
        .apb_prdata(prdata16), .irq(irq16)
    );

    // kind: 0 prdata, 1 irq, 2 prdata of the 16-bit instance, 4 prdata|irq
    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        probe = 1'b0;
    int          pos[2];
    exp_t        mon_e;
    logic [31:0] mon_act;

    always @(negedge sys_clock) begin
        if ((apb_psel && apb_penable && !apb_pwrite) || probe) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output prdata=%h irq=%b with empty scoreboard", apb_prdata, irq);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                case (mon_e.kind)
                    0:       mon_act = apb_prdata;
                    1:       mon_act = {30'd0, irq};
                    2:       mon_act = prdata16;
                    4:       mon_act = apb_prdata | {30'd0, irq};
                    default: mon_act = 32'hDEAD_BEEF;
                endcase
                if (mon_act !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s actual=%h required=%h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] seq(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic waitc(input int n);
        repeat (n) begin
            @(posedge sys_clock);
            #1;
        end
    endtask

    task automatic push(input int kind, input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = kind;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_penable = 1'b0;
        apb_paddr = a; apb_pwdata = d;
        @(posedge sys_clock); #1;
        apb_penable = 1'b1;
        @(posedge sys_clock); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic rd_k(input int kind, input logic [11:0] a, input logic [31:0] e, input string nm);
        push(kind, e, nm);
        apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0; apb_paddr = a;
        @(posedge sys_clock); #1;
        apb_penable = 1'b1;
        @(posedge sys_clock); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string nm);
        rd_k(0, a, e, nm);
    endtask

    task automatic probe_chk(input int kind, input logic [31:0] e, input string nm);
        push(kind, e, nm);
        probe = 1'b1;
        @(posedge sys_clock); #1;
        probe = 1'b0;
    endtask

    task automatic set_ab(input int ch, input logic [1:0] ab);
        enc_a[ch] = ab[1];
        enc_b[ch] = ab[0];
    endtask

    task automatic step1(input int ch, input bit fwd, input int hold);
        pos[ch] = fwd ? (pos[ch] + 1) % 4 : (pos[ch] + 3) % 4;
        set_ab(ch, seq(pos[ch]));
        waitc(hold);
    endtask

    task automatic quad(input int ch, input bit fwd, input int cycles);
        repeat (cycles * 4) step1(ch, fwd, 8);
    endtask

    initial begin
        reset = 1'b1;
        enc_a = 2'b00; enc_b = 2'b00; enc_z = 2'b00;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = 12'h000; apb_pwdata = 32'd0;
        pos[0] = 0; pos[1] = 0;
        waitc(3);
        probe_chk(4, 32'd0, "outputs_in_reset");
        reset = 1'b0;
        waitc(2);

        // Reset state
        rd(12'h000, 32'd0, "ctrl0_reset");
        rd(12'h004, 32'd0, "count0_reset");
        rd(12'h00C, 32'd0, "stat0_reset");
        rd(12'h018, 32'd0, "capture1_reset");

        // x4 forward / reverse, then x1
        wr(12'h000, 32'h0000_0001);
        quad(0, 1'b1, 10);
        rd(12'h004, 32'd40, "x4_fwd_40");
        quad(0, 1'b0, 3);
        rd(12'h004, 32'd28, "x4_rev_28");
        wr(12'h000, 32'h0000_0005);
        wr(12'h004, 32'd0);
        quad(0, 1'b1, 10);
        rd(12'h004, 32'd10, "x1_fwd_10");

        // Wrap below zero on both counter widths
        wr(12'h000, 32'h0000_0001);
        wr(12'h004, 32'd0);
        step1(0, 1'b0, 8);
        rd(12'h004, 32'hFFFF_FFFF, "wrap_32");
        rd_k(2, 12'h004, 32'h0000_FFFF, "wrap_16");
        step1(0, 1'b1, 8);
        rd(12'h004, 32'd0, "wrap_back_0");

        // Glitch filter, filt=3
        wr(12'h000, 32'h0000_0301);
        rd(12'h000, 32'h0000_0301, "ctrl_readback");
        enc_a[0] = 1'b1;
        waitc(3);
        enc_a[0] = 1'b0;
        waitc(10);
        rd(12'h004, 32'd0, "glitch_ignored");
        // Pin edge just after edge e0: COUNT must update on e7.
        step1(0, 1'b1, 6);
        rd(12'h004, 32'd0, "lat_setup_e7_old");
        rd(12'h004, 32'd1, "lat_setup_e9_new");
        step1(0, 1'b1, 5);
        rd(12'h004, 32'd1, "lat_setup_e6_old");
        rd(12'h004, 32'd2, "lat_setup_e8_new");
        step1(0, 1'b1, 8);
        step1(0, 1'b1, 8);
        rd(12'h004, 32'd4, "filtered_cycle_4");

        // Index capture with zclr and interrupt
        wr(12'h000, 32'h0000_0031);
        wr(12'h004, 32'd123);
        enc_z[0] = 1'b1;
        waitc(4);
        probe_chk(1, 32'd0, "irq_before_flag");
        probe_chk(1, 32'd1, "irq_after_flag");
        rd(12'h008, 32'd123, "capture_123");
        rd(12'h004, 32'd0, "zclr_count_0");
        rd(12'h00C, 32'd1, "stat_idx");
        wr(12'h00C, 32'd1);
        rd(12'h00C, 32'd0, "stat_idx_w1c");
        probe_chk(1, 32'd0, "irq_idx_cleared");
        enc_z[0] = 1'b0;
        waitc(8);

        // Illegal transition: both phases change together
        wr(12'h000, 32'h0000_0041);
        set_ab(0, 2'b11);
        pos[0] = 2;
        waitc(8);
        rd(12'h004, 32'd0, "illegal_no_count");
        rd(12'h00C, 32'd2, "stat_err");
        probe_chk(1, 32'd1, "irq_err");
        step1(0, 1'b1, 8);
        step1(0, 1'b1, 8);
        rd(12'h004, 32'd2, "steps_after_err");
        wr(12'h00C, 32'd2);
        rd(12'h00C, 32'd0, "stat_err_w1c");
        probe_chk(1, 32'd0, "irq_err_cleared");

        // APB write colliding with a step on the same edge
        step1(0, 1'b1, 2);
        wr(12'h004, 32'h0000_0055);
        waitc(6);
        rd(12'h004, 32'h0000_0055, "write_beats_step");

        // Channel 1 independence and unmapped read
        wr(12'h010, 32'h0000_0001);
        quad(1, 1'b1, 2);
        rd(12'h014, 32'd8, "ch1_count_8");
        rd(12'h004, 32'h0000_0055, "ch0_untouched");
        rd(12'hFC0, 32'd0, "unmapped_zero");

        // Asynchronous reset mid-operation
        set_ab(0, 2'b01);
        pos[0] = 3;
        waitc(8);
        probe_chk(1, 32'd1, "irq_err_before_reset");
        rd(12'h004, 32'h0000_0055, "count_before_reset");
        step1(1, 1'b1, 2);
        reset = 1'b1;
        probe_chk(4, 32'd0, "outputs_async_reset");
        waitc(2);
        reset = 1'b0;
        waitc(2);
        rd(12'h000, 32'd0, "ctrl0_after_reset");
        rd(12'h004, 32'd0, "count0_after_reset");
        rd(12'h008, 32'd0, "capture0_after_reset");
        rd(12'h00C, 32'd0, "stat0_after_reset");
        rd(12'h014, 32'd0, "count1_after_reset");
        probe_chk(1, 32'd0, "irq_after_reset");

        waitc(4);
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
